// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: core MEM-stage port plus debug/loader port onto one synchronous RAM
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), asynchronous active-low reset
//   i_core_*                 core request: req, we, size (0 byte/1 half/2 word), unsigned, byte addr, wdata
//   o_core_*                 core response: ready (completes this cycle), rvalid, rdata, misalign
//   o_stall                  core must hold its request (i_core_req and not o_core_ready)
//   i_dbg_*, o_dbg_*         debug/loader word-addressed port: req, we, addr, wdata / gnt, rvalid, rdata
//   o_ram_*, i_ram_rdata     RAM port; read data is valid the cycle after the address is presented
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [1:0]            i_core_size,
  input  logic                  i_core_unsigned,
  input  logic [ADDR_WIDTH+1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic                  o_core_ready,
  output logic                  o_core_rvalid,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_core_misalign,
  output logic                  o_stall,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RMW    = 2'd2,
    DBG_RD = 2'd3
  } state_t;

  state_t state, next_state;
  logic [CW-1:0] starve_cnt;

  // Unqualified internal versions of the outputs; the ports below are
  // forced to zero while reset is asserted.
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  core_ready;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  core_misalign;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [DATA_WIDTH-1:0] dbg_rdata;

  logic                  misalign;
  logic                  dbg_wins;
  logic [ADDR_WIDTH-1:0] core_word_addr;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_merge;

  assign core_word_addr = i_core_addr[ADDR_WIDTH+1:2];

  assign misalign = ((i_core_size == SZ_HALF) && i_core_addr[0]) ||
                    ((i_core_size == SZ_WORD) && (i_core_addr[1:0] != 2'b00)) ||
                    (i_core_size == 2'd3);

  // Core normally wins; a starved debug request takes the next IDLE slot.
  assign dbg_wins = i_dbg_req && (!i_core_req || (starve_cnt == STARVE_LIM));

  // Load extraction works on the live core inputs, which the core holds
  // stable through the LOAD cycle.
  always_comb begin
    byte_val = 8'h00;
    case (i_core_addr[1:0])
      2'd0:    byte_val = i_ram_rdata[7:0];
      2'd1:    byte_val = i_ram_rdata[15:8];
      2'd2:    byte_val = i_ram_rdata[23:16];
      default: byte_val = i_ram_rdata[31:24];
    endcase
    half_val  = i_core_addr[1] ? i_ram_rdata[31:16] : i_ram_rdata[15:0];
    load_data = i_ram_rdata;
    if (i_core_size == SZ_BYTE) begin
      load_data = i_core_unsigned ? {24'h000000, byte_val} : {{24{byte_val[7]}}, byte_val};
    end else if (i_core_size == SZ_HALF) begin
      load_data = i_core_unsigned ? {16'h0000, half_val} : {{16{half_val[15]}}, half_val};
    end
  end

  // Sub-word store: old word from RAM with only the addressed lanes replaced.
  always_comb begin
    store_merge = i_ram_rdata;
    if (i_core_size == SZ_BYTE) begin
      case (i_core_addr[1:0])
        2'd0:    store_merge[7:0]   = i_core_wdata[7:0];
        2'd1:    store_merge[15:8]  = i_core_wdata[7:0];
        2'd2:    store_merge[23:16] = i_core_wdata[7:0];
        default: store_merge[31:24] = i_core_wdata[7:0];
      endcase
    end else if (i_core_addr[1]) begin
      store_merge[31:16] = i_core_wdata[15:0];
    end else begin
      store_merge[15:0] = i_core_wdata[15:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (dbg_gnt) begin
      starve_cnt <= '0;
    end else if (i_dbg_req && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state    = state;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    core_ready    = 1'b0;
    core_rvalid   = 1'b0;
    core_rdata    = '0;
    core_misalign = 1'b0;
    dbg_gnt       = 1'b0;
    dbg_rvalid    = 1'b0;
    dbg_rdata     = '0;
    case (state)
      IDLE: begin
        if (dbg_wins) begin
          dbg_gnt  = 1'b1;
          ram_addr = i_dbg_addr;
          if (i_dbg_we) begin
            ram_we    = 1'b1;
            ram_wdata = i_dbg_wdata;
          end else begin
            next_state = DBG_RD;
          end
        end else if (i_core_req) begin
          if (misalign) begin
            core_ready    = 1'b1;
            core_misalign = 1'b1;
          end else begin
            ram_addr = core_word_addr;
            if (!i_core_we) begin
              next_state = LOAD;
            end else if (i_core_size == SZ_WORD) begin
              ram_we     = 1'b1;
              ram_wdata  = i_core_wdata;
              core_ready = 1'b1;
            end else begin
              next_state = RMW;
            end
          end
        end
      end
      LOAD: begin
        core_ready  = 1'b1;
        core_rvalid = 1'b1;
        core_rdata  = load_data;
        next_state  = IDLE;
      end
      RMW: begin
        ram_we     = 1'b1;
        ram_addr   = core_word_addr;
        ram_wdata  = store_merge;
        core_ready = 1'b1;
        next_state = IDLE;
      end
      DBG_RD: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = i_ram_rdata;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Reset forces every output low at once, even though they are combinational.
  assign o_ram_we        = i_rst_n & ram_we;
  assign o_ram_addr      = i_rst_n ? ram_addr : '0;
  assign o_ram_wdata     = i_rst_n ? ram_wdata : '0;
  assign o_core_ready    = i_rst_n & core_ready;
  assign o_core_rvalid   = i_rst_n & core_rvalid;
  assign o_core_rdata    = i_rst_n ? core_rdata : '0;
  assign o_core_misalign = i_rst_n & core_misalign;
  assign o_stall         = i_rst_n & i_core_req & ~core_ready;
  assign o_dbg_gnt       = i_rst_n & dbg_gnt;
  assign o_dbg_rvalid    = i_rst_n & dbg_rvalid;
  assign o_dbg_rdata     = i_rst_n ? dbg_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl with a behavioural synchronous RAM
module tb_dmem_ctrl;

  localparam int AW = 9;

  logic          clk;
  logic          rst_n;
  logic          core_req;
  logic          core_we;
  logic [1:0]    core_size;
  logic          core_unsigned;
  logic [AW+1:0] core_addr;
  logic [31:0]   core_wdata;
  logic          core_ready;
  logic          core_rvalid;
  logic [31:0]   core_rdata;
  logic          core_misalign;
  logic          stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [31:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int gnt_at;

  dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .STARVE_MAX(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_size(core_size),
    .i_core_unsigned(core_unsigned), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
    .o_core_ready(core_ready), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
    .o_core_misalign(core_misalign), .o_stall(stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    core_req = 1'b0; core_we = 1'b0; core_size = 2'd0;
    core_unsigned = 1'b0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic dbg_write(input logic [AW-1:0] a, input logic [31:0] d);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    chk("dbg_wr_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("dbg_wr_we", {31'd0, ram_we}, 32'd1);
    next_cycle();
    dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic dbg_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
    @(negedge clk);
    chk("dbg_rd_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("dbg_rd_zero", dbg_rdata, 32'd0);
    next_cycle();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk(tag, dbg_rdata, exp);
    next_cycle();
  endtask

  task automatic core_load(input string tag, input logic [AW+1:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] exp);
    core_req = 1'b1; core_we = 1'b0; core_size = sz; core_unsigned = uns; core_addr = a;
    @(negedge clk);
    chk("ld_stall", {31'd0, stall}, 32'd1);
    chk("ld_raddr", {23'd0, ram_addr}, {23'd0, a[AW+1:2]});
    chk("ld_rdata_idle", core_rdata, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("ld_ready", {30'd0, core_rvalid, core_ready}, 32'd3);
    chk("ld_nostall", {31'd0, stall}, 32'd0);
    chk(tag, core_rdata, exp);
    next_cycle();
    core_idle();
  endtask

  task automatic core_sub_store(input string tag, input logic [AW+1:0] a, input logic [1:0] sz,
                                input logic [31:0] d, input logic [31:0] exp);
    core_req = 1'b1; core_we = 1'b1; core_size = sz; core_addr = a; core_wdata = d;
    @(negedge clk);
    chk("st_c1_stall", {31'd0, stall}, 32'd1);
    chk("st_c1_we", {31'd0, ram_we}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("st_c2_we_rdy", {30'd0, ram_we, core_ready}, 32'd3);
    chk("st_c2_addr", {23'd0, ram_addr}, {23'd0, a[AW+1:2]});
    chk(tag, ram_wdata, exp);
    next_cycle();
    core_idle();
  endtask

  task automatic misalign_case(input string tag, input logic [AW+1:0] a, input logic [1:0] sz,
                               input logic we);
    core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    // {misalign, ready, ram_we, stall}
    chk(tag, {28'd0, core_misalign, core_ready, ram_we, stall}, 32'b1100);
    chk("mis_rdata", core_rdata, 32'd0);
    next_cycle();
    core_idle();
  endtask

  task automatic starve_round(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    core_req = 1'b1; core_we = 1'b0; core_size = 2'd2; core_unsigned = 1'b0; core_addr = 11'h010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
    gnt_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_gnt) begin
        gnt_at = i;
        break;
      end
      next_cycle();
    end
    chk(tag, gnt_at, 32'd8);
    if (gnt_at >= 0) begin
      next_cycle();
      dbg_req = 1'b0;
      @(negedge clk);
      chk("starve_rvalid", {31'd0, dbg_rvalid}, 32'd1);
      chk("starve_rdata", dbg_rdata, exp);
      chk("starve_core_stall", {31'd0, stall}, 32'd1);
      next_cycle();
    end
    dbg_req = 1'b0;
    // Let any core load in flight finish before the next test.
    @(negedge clk);
    if (core_ready) begin
      next_cycle();
    end else begin
      next_cycle();
      next_cycle();
    end
    core_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    core_idle();
    core_req = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #3;
    chk("rst_outs", {26'd0, stall, core_ready, core_rvalid, dbg_gnt, dbg_rvalid, ram_we}, 32'd0);
    chk("rst_raddr", {23'd0, ram_addr}, 32'd0);
    core_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Aligned word store completes in the request cycle.
    core_req = 1'b1; core_we = 1'b1; core_size = 2'd2; core_addr = 11'h010; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sw_we_rdy_stall", {29'd0, ram_we, core_ready, stall}, 32'b110);
    chk("sw_addr", {23'd0, ram_addr}, 32'd4);
    chk("sw_wdata", ram_wdata, 32'hDEADBEEF);
    next_cycle();
    core_idle();
    dbg_read("sw_readback", 9'd4, 32'hDEADBEEF);

    // Loads with lane extraction and sign/zero extension.
    dbg_write(9'd4, 32'h80FF7F01);
    core_load("lb_011", 11'h011, 2'd0, 1'b0, 32'h0000007F);
    core_load("lbu_013", 11'h013, 2'd0, 1'b1, 32'h00000080);
    core_load("lb_013", 11'h013, 2'd0, 1'b0, 32'hFFFFFF80);
    core_load("lh_012", 11'h012, 2'd1, 1'b0, 32'hFFFF80FF);
    core_load("lhu_010", 11'h010, 2'd1, 1'b1, 32'h00007F01);
    core_load("lw_010", 11'h010, 2'd2, 1'b0, 32'h80FF7F01);

    // Read-modify-write sub-word stores.
    dbg_write(9'd4, 32'h11223344);
    core_sub_store("sb_012", 11'h012, 2'd0, 32'h000000AA, 32'h11AA3344);
    dbg_read("sb_readback", 9'd4, 32'h11AA3344);
    core_sub_store("sh_010", 11'h010, 2'd1, 32'hFFFF5566, 32'h11AA5566);
    core_sub_store("sh_012", 11'h012, 2'd1, 32'h00007788, 32'h77885566);
    dbg_read("sh_readback", 9'd4, 32'h77885566);

    // Misaligned accesses.
    misalign_case("mis_lw_011", 11'h011, 2'd2, 1'b0);
    misalign_case("mis_sh_013", 11'h013, 2'd1, 1'b1);
    misalign_case("mis_size3", 11'h010, 2'd3, 1'b0);

    // Debug starvation under back-to-back core loads; second round shows the counter cleared.
    dbg_write(9'd7, 32'hCAFEF00D);
    starve_round("starve_wait1", 9'd7, 32'hCAFEF00D);
    starve_round("starve_wait2", 9'd7, 32'hCAFEF00D);

    // Reset in the RMW cycle: no write, outputs low at once, clean IDLE after release.
    dbg_write(9'd5, 32'h01020304);
    core_req = 1'b1; core_we = 1'b1; core_size = 2'd0; core_addr = 11'h014; core_wdata = 32'h000000FF;
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_outs", {27'd0, ram_we, core_ready, stall, core_rvalid, dbg_rvalid}, 32'd0);
    chk("rmw_rst_wdata", ram_wdata, 32'd0);
    next_cycle();
    core_idle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post_rst_quiet", {29'd0, core_rvalid, dbg_rvalid, ram_we}, 32'd0);
    next_cycle();
    dbg_read("rmw_rst_nowrite", 9'd5, 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning word-address width of the data RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning RAM word width; only 32 is supported.
REQ-003 SHALL have parameter STARVE_MAX, default 8, meaning debug wait cycles before debug gets priority.
REQ-004 SHALL have port i_clk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_core_req in 1, i_core_we in 1, i_core_size in 2 (0 byte, 1 half, 2 word), i_core_unsigned in 1: MEM-stage request.
REQ-007 SHALL have ports i_core_addr in ADDR_WIDTH+2 (byte address) and i_core_wdata in 32 (store data, low-aligned).
REQ-008 SHALL have ports o_core_ready out 1 (request completes this cycle), o_core_rvalid out 1, o_core_rdata out 32, o_core_misalign out 1, o_stall out 1.
REQ-009 SHALL have ports i_dbg_req in 1, i_dbg_we in 1, i_dbg_addr in ADDR_WIDTH (word address), i_dbg_wdata in 32: loader/debug port.
REQ-010 SHALL have ports o_dbg_gnt out 1, o_dbg_rvalid out 1, o_dbg_rdata out 32.
REQ-011 SHALL have ports o_ram_we out 1, o_ram_addr out ADDR_WIDTH, o_ram_wdata out 32, i_ram_rdata in 32 (RAM read data valid one cycle after address).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RMW, DBG_RD; RAM outputs are combinational from state and accepted request.
REQ-013 SHALL in IDLE arbitrate core over debug, except debug wins when starvation counter equals STARVE_MAX.
REQ-014 SHALL increment the starvation counter (saturating at STARVE_MAX) each cycle i_dbg_req is high without o_dbg_gnt, and clear it on o_dbg_gnt.
REQ-015 SHALL flag misalignment when size=1 and addr[0]=1, or size=2 and addr[1:0]!=0, or size=3: o_core_misalign=1, o_core_ready=1, o_core_rdata=0, no RAM access, stay IDLE.
REQ-016 SHALL complete an aligned word store in IDLE in one cycle: o_ram_we=1, addr=i_core_addr[ADDR_WIDTH+1:2], wdata=i_core_wdata, o_core_ready=1.
REQ-017 SHALL for a load drive the read address in IDLE, go to LOAD, then in LOAD assert o_core_ready and o_core_rvalid with extracted data and return to IDLE.
REQ-018 SHALL extract little-endian: byte lane addr[1:0], half lane addr[1]; sign-extend unless i_core_unsigned=1; word unmodified.
REQ-019 SHALL for byte/half stores read in IDLE, go to RMW, write i_ram_rdata with the addressed lanes replaced in RMW, assert o_core_ready, return to IDLE.
REQ-020 SHALL keep core request inputs stable while o_stall is high; the controller captures nothing from them.
REQ-021 SHALL drive o_stall = i_core_req AND NOT o_core_ready.
REQ-022 SHALL on debug grant in IDLE assert o_dbg_gnt one cycle; write completes that cycle, read goes to DBG_RD, which asserts o_dbg_rvalid with i_ram_rdata and returns to IDLE.
REQ-023 SHALL never grant debug outside IDLE, and never drive o_ram_we in LOAD or DBG_RD.
REQ-024 SHALL hold o_core_rdata and o_dbg_rdata at 0 when their rvalid is low.

Reset
REQ-025 SHALL on i_rst_n low immediately force state IDLE, starvation counter 0, and all outputs 0.
REQ-026 SHALL abandon an in-flight LOAD/RMW/DBG_RD on reset with no RAM write and no rvalid after release.

Verification
REQ-027 Word store addr 0x010 data 0xDEADBEEF -> same cycle ram_we=1, ram_addr=4, ready=1, stall=0.
REQ-028 RAM[4]=0x80FF7F01; lb 0x011 -> one stall cycle, rdata 0x0000007F; lbu 0x013 -> 0x00000080; lh 0x012 -> 0xFFFF80FF.
REQ-029 RAM[4]=0x11223344; sb 0x012 data 0xAA -> read cycle then write 0x11AA3344, ready on cycle 2.
REQ-030 lw 0x011 -> misalign=1, ready=1, rdata=0, ram_we=0, no stall.
REQ-031 Continuous core loads plus debug read word 7 -> dbg_gnt after ≤STARVE_MAX (8) waiting cycles, dbg_rvalid next cycle with RAM[7], counter clears.
REQ-032 Reset asserted during RMW cycle -> no RAM write, all outputs 0 immediately, IDLE after release.
